ysyx_2022040010_div: RTL and testbench



---
 rtl/ysyx_2022040010_div.sv | 156 +++++++++++++++
 tb/tb_ysyx_2022040010_div.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_2022040010_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/REM (signed, unsigned, word forms).
// One quotient bit per clock; divide-by-zero and signed overflow complete in a single cycle.
module ysyx_2022040010_div (
  input  logic        clk,
  input  logic        ret,
  input  logic        div_valid,
  input  logic        div_flush,
  input  logic        div_signed,
  input  logic        div_32,
  input  logic        sel_div_qr,
  input  logic [63:0] ina,
  input  logic [63:0] inb,
  output logic        div_ready,
  output logic [63:0] div_result,
  output logic        div_over
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        sel_qr_q, sel_qr_d;
  logic        w32_q, w32_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic [63:0] abs_b_q, abs_b_d;
  logic [63:0] rem_q, rem_d;
  logic [63:0] quo_q, quo_d;
  logic [63:0] result_q, result_d;
  logic        over_q, over_d;

  logic [63:0] a_eff, b_eff, a_abs, b_abs;
  logic        a_neg, b_neg, b_zero, ovf;
  logic [63:0] fast_sel, fast_res;
  logic [64:0] r_shift;
  logic        ge;
  logic [63:0] rem_next, quo_next, q_fix, r_fix, fin_sel, fin_res;

  always_comb begin
    a_eff = ina;
    b_eff = inb;
    if (div_32) begin
      a_eff = {{32{div_signed & ina[31]}}, ina[31:0]};
      b_eff = {{32{div_signed & inb[31]}}, inb[31:0]};
    end
    a_neg  = div_signed & a_eff[63];
    b_neg  = div_signed & b_eff[63];
    a_abs  = a_neg ? (64'd0 - a_eff) : a_eff;
    b_abs  = b_neg ? (64'd0 - b_eff) : b_eff;
    b_zero = (b_eff == 64'd0);
    ovf    = div_signed && (b_eff == 64'hFFFF_FFFF_FFFF_FFFF) &&
             (a_eff == (div_32 ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    // Both special cases return A as one of the results; the other is all-ones or zero.
    if (sel_div_qr) fast_sel = b_zero ? a_eff : 64'd0;
    else            fast_sel = b_zero ? 64'hFFFF_FFFF_FFFF_FFFF : a_eff;
    fast_res = div_32 ? {{32{fast_sel[31]}}, fast_sel[31:0]} : fast_sel;
  end

  // Restoring step: the dividend is shifted out of the top of quo_q as quotient bits enter below.
  always_comb begin
    r_shift  = {rem_q, quo_q[63]};
    ge       = r_shift[64] | (r_shift[63:0] >= abs_b_q);
    rem_next = ge ? (r_shift[63:0] - abs_b_q) : r_shift[63:0];
    quo_next = {quo_q[62:0], ge};
    q_fix    = (neg_a_q ^ neg_b_q) ? (64'd0 - quo_next) : quo_next;
    r_fix    = neg_a_q ? (64'd0 - rem_next) : rem_next;
    fin_sel  = sel_qr_q ? r_fix : q_fix;
    fin_res  = w32_q ? {{32{fin_sel[31]}}, fin_sel[31:0]} : fin_sel;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_qr_d = sel_qr_q;
    w32_d    = w32_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    abs_b_d  = abs_b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    over_d   = 1'b0;
    if (div_flush) begin
      state_d = S_IDLE;
      cnt_d   = 7'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_valid) begin
            sel_qr_d = sel_div_qr;
            w32_d    = div_32;
            neg_a_d  = a_neg;
            neg_b_d  = b_neg;
            abs_b_d  = b_abs;
            rem_d    = 64'd0;
            quo_d    = div_32 ? {a_abs[31:0], 32'd0} : a_abs;
            cnt_d    = div_32 ? 7'd32 : 7'd64;
            if (b_zero || ovf) begin
              state_d  = S_DONE;
              over_d   = 1'b1;
              result_d = fast_res;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          rem_d = rem_next;
          quo_d = quo_next;
          cnt_d = cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            state_d  = S_DONE;
            over_d   = 1'b1;
            result_d = fin_res;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge ret) begin
    if (ret) begin
      state_q  <= S_IDLE;
      cnt_q    <= 7'd0;
      sel_qr_q <= 1'b0;
      w32_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      abs_b_q  <= 64'd0;
      rem_q    <= 64'd0;
      quo_q    <= 64'd0;
      result_q <= 64'd0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_qr_q <= sel_qr_d;
      w32_q    <= w32_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      abs_b_q  <= abs_b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      over_q   <= over_d;
    end
  end

  assign div_ready  = (state_q == S_IDLE);
  assign div_result = result_q;
  assign div_over   = over_q;

endmodule

// File: tb/tb_ysyx_2022040010_div.sv
// Scoreboard bench for the iterative divider: reference model, latency checks and control cases.
module tb_ysyx_2022040010_div;

  logic        clk = 1'b0;
  logic        ret = 1'b1;
  logic        div_valid = 1'b0, div_flush = 1'b0, div_signed = 1'b0, div_32 = 1'b0, sel_div_qr = 1'b0;
  logic [63:0] ina = '0, inb = '0;
  logic        div_ready, div_over;
  logic [63:0] div_result;

  ysyx_2022040010_div dut (
    .clk(clk), .ret(ret), .div_valid(div_valid), .div_flush(div_flush),
    .div_signed(div_signed), .div_32(div_32), .sel_div_qr(sel_div_qr),
    .ina(ina), .inb(inb), .div_ready(div_ready), .div_result(div_result), .div_over(div_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic w, input logic qr,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0] q, r;
    logic signed [63:0] sa, sb_;
    logic signed [31:0] sa32, sb32;
    logic [31:0] a32, b32, q32, r32, pick;
    if (w) begin
      a32 = a[31:0]; b32 = b[31:0];
      if (b32 == 32'd0) begin q32 = 32'hFFFF_FFFF; r32 = a32; end
      else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 32'd0; end
      else if (sgn) begin
        sa32 = a32; sb32 = b32;
        q32 = sa32 / sb32; r32 = sa32 % sb32;
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      pick = qr ? r32 : q32;
      return {{32{pick[31]}}, pick};
    end
    if (b == 64'd0) begin q = '1; r = a; end
    else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = 64'd0; end
    else if (sgn) begin
      sa = a; sb_ = b;
      q = sa / sb_; r = sa % sb_;
    end else begin
      q = a / b; r = a % b;
    end
    return qr ? r : q;
  endfunction

  function automatic int exp_lat(input logic sgn, input logic w, input logic [63:0] a, input logic [63:0] b);
    if (w) begin
      if (b[31:0] == 32'd0 || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)) return 0;
      return 32;
    end
    if (b == 64'd0 || (sgn && a == 64'h8000_0000_0000_0000 && b == '1)) return 0;
    return 64;
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!div_ready && n < 200) begin @(negedge clk); n++; end
    if (!div_ready) check("ready_timeout", 64'd0, 64'd1);
  endtask

  // Drives one request; the accepting edge is the next posedge.
  task automatic issue(input logic sgn, input logic w, input logic qr,
                       input logic [63:0] a, input logic [63:0] b, input bit push);
    exp_t e;
    wait_ready();
    div_signed = sgn; div_32 = w; sel_div_qr = qr; ina = a; inb = b; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    ina = $urandom; inb = $urandom;
    if (push) begin
      e.res = model(sgn, w, qr, a, b);
      e.lat = exp_lat(sgn, w, a, b);
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int n = 0;
    while (!div_over && n < 100) begin @(posedge clk); #1; n++; end
    if (sb.size() == 0) begin check({tag, "_sb_underflow"}, 64'd0, 64'd1); return; end
    e = sb.pop_front();
    if (!div_over) begin check({tag, "_timeout"}, 64'd0, 64'd1); return; end
    check({tag, "_res"}, div_result, e.res);
    check({tag, "_lat"}, 64'(cyc - e.acc), 64'(e.lat));
    @(posedge clk); #1;
    check({tag, "_over_drop"}, {63'd0, div_over}, 64'd0);
    check({tag, "_hold"}, div_result, e.res);
  endtask

  task automatic op(input string tag, input logic sgn, input logic w, input logic qr,
                    input logic [63:0] a, input logic [63:0] b);
    issue(sgn, w, qr, a, b, 1'b1);
    collect(tag);
  endtask

  initial begin
    logic [63:0] ra, rb, seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, div_ready}, 64'd1);
    check("rst_over", {63'd0, div_over}, 64'd0);
    check("rst_result", div_result, 64'd0);
    @(negedge clk); ret = 1'b0;

    op("divu_q", 1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
    op("divu_r", 1'b0, 1'b0, 1'b1, 64'd100, 64'd7);
    op("div_q", 1'b1, 1'b0, 1'b0, -64'sd7, 64'd2);
    op("div_r", 1'b1, 1'b0, 1'b1, -64'sd7, 64'd2);
    op("dz_q", 1'b1, 1'b0, 1'b0, 64'd5, 64'd0);
    op("dz_r", 1'b1, 1'b0, 1'b1, 64'd5, 64'd0);
    op("ovf_q", 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, '1);
    op("ovf_r", 1'b1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, '1);
    op("divw_ovf", 1'b1, 1'b1, 1'b0, 64'h0000_0000_8000_0000, '1);
    op("divuw", 1'b0, 1'b1, 1'b0, 64'h1234_5678_FFFF_FFFE, 64'd1);
    op("remw_neg", 1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'd3);
    op("divuw_dz", 1'b0, 1'b1, 1'b1, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000);

    for (int i = 0; i < 16; i++) begin
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 2) == 0) ? 64'($urandom_range(1, 40)) : {$urandom, $urandom};
      if (i[1:0] == 2'd3) rb = {32'd0, $urandom} >> $urandom_range(0, 31);
      op($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), 1'($urandom), ra, rb);
    end

    // Flush during RUN: no completion, ready again immediately.
    issue(1'b0, 1'b0, 1'b0, 64'd1000, 64'd3, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk); div_flush = 1'b1;
    @(posedge clk); #1; div_flush = 1'b0;
    check("flush_ready", {63'd0, div_ready}, 64'd1);
    seen = 64'd0;
    repeat (70) begin @(posedge clk); #1; if (div_over) seen = 64'd1; end
    check("flush_no_over", seen, 64'd0);
    op("after_flush", 1'b1, 1'b0, 1'b1, -64'sd1000, 64'd7);

    // Flush and valid together in IDLE: nothing accepted.
    @(negedge clk); div_valid = 1'b1; div_flush = 1'b1; inb = 64'd0;
    @(posedge clk); #1; div_valid = 1'b0; div_flush = 1'b0;
    check("flush_wins", {62'd0, div_ready, div_over}, 64'd2);

    // A valid pulse mid-RUN must not disturb the running op nor start another.
    issue(1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk); div_valid = 1'b1; ina = 64'd9; inb = 64'd0; div_32 = 1'b1;
    @(posedge clk); #1; div_valid = 1'b0;
    collect("valid_in_run");
    seen = 64'd0;
    repeat (70) begin @(posedge clk); #1; if (div_over) seen = 64'd1; end
    check("no_second_op", seen, 64'd0);

    // Reset mid-RUN.
    issue(1'b1, 1'b0, 1'b0, 64'd12345, 64'd11, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk); ret = 1'b1;
    #1;
    check("ret_result", div_result, 64'd0);
    check("ret_over_ready", {62'd0, div_ready, div_over}, 64'd2);
    @(negedge clk); ret = 1'b0;
    seen = 64'd0;
    repeat (70) begin @(posedge clk); #1; if (div_over) seen = 64'd1; end
    check("ret_no_over", seen, 64'd0);
    op("after_ret", 1'b0, 1'b1, 1'b0, 64'd77, 64'd8);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
